// File: rtl/mem_arbiter.sv
// Two-port arbiter between instruction fetch and data accesses onto a single
// halfword-wide memory; word accesses are split into two big-endian beats.
module mem_arbiter #(
   parameter  int MEM_DEPTH  = 2**12,
   localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic                  o_if_gnt,
   output logic                  o_if_valid,
   output logic [15:0]           o_if_data,
   input  logic                  i_d_req,
   input  logic                  i_d_we,
   input  logic [1:0]            i_d_size,
   input  logic [ADDR_WIDTH-1:0] i_d_addr,
   input  logic [31:0]           i_d_wdata,
   output logic                  o_d_gnt,
   output logic                  o_d_valid,
   output logic [31:0]           o_d_rdata,
   output logic                  o_d_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_en,
   output logic                  o_mem_rd_en,
   output logic [0:1]            o_mem_wr_en,
   output logic [0:1][7:0]       o_mem_di,
   input  logic [0:1][7:0]       i_mem_do
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BEAT1 = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   logic [1:0]            state, next_state;
   logic                  last_data;
   logic                  owner_data;
   logic                  lat_we;
   logic                  lat_err;
   logic [1:0]            lat_size;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [15:0]           lat_wdata_lo;
   logic [15:0]           high;
   logic                  gnt_if, gnt_d, d_err_in;
   logic [ADDR_WIDTH-1:0] beat2_addr;

   assign d_err_in   = (i_d_size == 2'b11) || (i_d_addr[0] && (i_d_size != SIZE_BYTE));
   assign beat2_addr = {lat_addr[ADDR_WIDTH-1:1], 1'b0} + ADDR_WIDTH'(2);

   // Grants and first memory command come straight from the request inputs in
   // IDLE; reset masks them so every output is quiet while rst is low.
   always_comb begin
      next_state  = state;
      gnt_if      = 1'b0;
      gnt_d       = 1'b0;
      o_mem_en    = 1'b0;
      o_mem_rd_en = 1'b0;
      o_mem_wr_en = 2'b00;
      o_mem_addr  = '0;
      o_mem_di    = '0;
      o_if_valid  = 1'b0;
      o_if_data   = 16'h0000;
      o_d_valid   = 1'b0;
      o_d_err     = 1'b0;
      o_d_rdata   = 32'h0;
      case (state)
         IDLE: begin
            if (rst) begin
               gnt_d  = i_d_req & (~i_if_req | ~last_data);
               gnt_if = i_if_req & ~gnt_d;
               if (gnt_if) begin
                  o_mem_en    = 1'b1;
                  o_mem_rd_en = 1'b1;
                  o_mem_addr  = {i_if_addr[ADDR_WIDTH-1:1], 1'b0};
                  next_state  = RESP;
               end else if (gnt_d) begin
                  next_state = (!d_err_in && i_d_size == SIZE_WORD) ? BEAT1 : RESP;
                  if (!d_err_in) begin
                     o_mem_en   = 1'b1;
                     o_mem_addr = {i_d_addr[ADDR_WIDTH-1:1], 1'b0};
                     if (!i_d_we) begin
                        o_mem_rd_en = 1'b1;
                     end else if (i_d_size == SIZE_BYTE) begin
                        o_mem_wr_en = i_d_addr[0] ? 2'b01 : 2'b10;
                        o_mem_di    = {i_d_wdata[7:0], i_d_wdata[7:0]};
                     end else if (i_d_size == SIZE_HALF) begin
                        o_mem_wr_en = 2'b11;
                        o_mem_di    = i_d_wdata[15:0];
                     end else begin
                        o_mem_wr_en = 2'b11;
                        o_mem_di    = i_d_wdata[31:16];
                     end
                  end
               end
            end
         end
         BEAT1: begin
            o_mem_en   = 1'b1;
            o_mem_addr = beat2_addr;
            if (lat_we) begin
               o_mem_wr_en = 2'b11;
               o_mem_di    = lat_wdata_lo;
            end else begin
               o_mem_rd_en = 1'b1;
            end
            next_state = RESP;
         end
         RESP: begin
            if (!owner_data) begin
               o_if_valid = 1'b1;
               o_if_data  = i_mem_do;
            end else begin
               o_d_valid = 1'b1;
               o_d_err   = lat_err;
               if (!lat_err && !lat_we) begin
                  case (lat_size)
                     SIZE_BYTE: o_d_rdata = {24'h0, lat_addr[0] ? i_mem_do[1] : i_mem_do[0]};
                     SIZE_HALF: o_d_rdata = {16'h0, i_mem_do};
                     default:   o_d_rdata = {high, i_mem_do};
                  endcase
               end
            end
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign o_if_gnt = gnt_if;
   assign o_d_gnt  = gnt_d;

   // Request attributes are captured once at grant so later input changes
   // cannot disturb an access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_data    <= 1'b0;
         owner_data   <= 1'b0;
         lat_we       <= 1'b0;
         lat_err      <= 1'b0;
         lat_size     <= 2'b00;
         lat_addr     <= '0;
         lat_wdata_lo <= 16'h0000;
         high         <= 16'h0000;
      end else begin
         state <= next_state;
         if (gnt_if || gnt_d) begin
            owner_data   <= gnt_d;
            last_data    <= gnt_d;
            lat_we       <= gnt_d & i_d_we;
            lat_err      <= gnt_d & d_err_in;
            lat_size     <= i_d_size;
            lat_addr     <= gnt_d ? i_d_addr : i_if_addr;
            lat_wdata_lo <= i_d_wdata[15:0];
         end
         if (state == BEAT1 && !lat_we) begin
            high <= i_mem_do;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array memory model behind the
// memory port and hand-computed expectations.
module tb_mem_arbiter;

   localparam int AW = 13;

   logic            clk;
   logic            rst;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_gnt, if_valid;
   logic [15:0]     if_data;
   logic            d_req, d_we;
   logic [1:0]      d_size;
   logic [AW-1:0]   d_addr;
   logic [31:0]     d_wdata;
   logic            d_gnt, d_valid, d_err;
   logic [31:0]     d_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_en, mem_rd_en;
   logic [0:1]      mem_wr_en;
   logic [0:1][7:0] mem_di;
   logic [0:1][7:0] mem_do;

   logic [7:0]      mem [0:8191];
   logic            load_en;
   logic [AW-1:0]   load_addr;
   logic [7:0]      load_data;

   int errors = 0;
   int checks = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_gnt(if_gnt), .o_if_valid(if_valid), .o_if_data(if_data),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr),
      .i_d_wdata(d_wdata),
      .o_d_gnt(d_gnt), .o_d_valid(d_valid), .o_d_rdata(d_rdata), .o_d_err(d_err),
      .o_mem_addr(mem_addr), .o_mem_en(mem_en), .o_mem_rd_en(mem_rd_en),
      .o_mem_wr_en(mem_wr_en), .o_mem_di(mem_di), .i_mem_do(mem_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous halfword memory: read data appears the cycle after a read.
   always @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end else if (mem_en) begin
         if (mem_rd_en) mem_do <= {mem[{mem_addr[AW-1:1], 1'b0}], mem[{mem_addr[AW-1:1], 1'b1}]};
         if (mem_wr_en[0]) mem[{mem_addr[AW-1:1], 1'b0}] <= mem_di[0];
         if (mem_wr_en[1]) mem[{mem_addr[AW-1:1], 1'b1}] <= mem_di[1];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
      load_en   = 1'b1;
      load_addr = a;
      load_data = v;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                                input logic dr, input logic we, input logic [1:0] sz,
                                input logic [AW-1:0] da, input logic [31:0] wd);
      if_req  = ir;
      if_addr = ia;
      d_req   = dr;
      d_we    = we;
      d_size  = sz;
      d_addr  = da;
      d_wdata = wd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      load_en = 1'b0; load_addr = '0; load_data = 8'h00;
      rst = 1'b0;
      applyStimulus(1'b1, 13'h0, 1'b1, 1'b0, 2'b01, 13'h0, 32'h0);
      checkOutput("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
      checkOutput("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
      checkOutput("rst_mem_en", {31'h0, mem_en}, 32'h0);
      checkOutput("rst_mem_addr", {19'h0, mem_addr}, 32'h0);
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);

      preload(13'h0010, 8'hA1); preload(13'h0011, 8'hB2);
      preload(13'h0020, 8'h11); preload(13'h0021, 8'h22);
      preload(13'h0022, 8'h33); preload(13'h0023, 8'h44);
      preload(13'h0030, 8'h77); preload(13'h0031, 8'h00);
      preload(13'h1FFE, 8'hDE); preload(13'h1FFF, 8'hAD);
      preload(13'h0000, 8'hBE); preload(13'h0001, 8'hEF);
      preload(13'h0062, 8'h00); preload(13'h0063, 8'h00);
      rst = 1'b1;
      tick();

      $display("[TB] fetch read");
      applyStimulus(1'b1, 13'h0010, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("fetch_gnt", {31'h0, if_gnt}, 32'h1);
      checkOutput("fetch_rd_en", {31'h0, mem_rd_en}, 32'h1);
      checkOutput("fetch_addr", {19'h0, mem_addr}, 32'h0010);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("fetch_valid", {31'h0, if_valid}, 32'h1);
      checkOutput("fetch_data", {16'h0, if_data}, 32'hA1B2);
      tick();
      checkOutput("fetch_valid_drop", {31'h0, if_valid}, 32'h0);

      $display("[TB] word read");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b10, 13'h0020, 32'h0);
      checkOutput("wr_gnt", {31'h0, d_gnt}, 32'h1);
      checkOutput("wr_addr0", {19'h0, mem_addr}, 32'h0020);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b1, 2'b00, 13'h0555, 32'hFFFF_FFFF);
      checkOutput("wr_addr1", {19'h0, mem_addr}, 32'h0022);
      checkOutput("wr_rd1", {31'h0, mem_rd_en}, 32'h1);
      checkOutput("wr_beat_wr_en", {30'h0, mem_wr_en}, 32'h0);
      tick();
      checkOutput("wr_valid", {31'h0, d_valid}, 32'h1);
      checkOutput("wr_rdata", d_rdata, 32'h11223344);
      tick();

      $display("[TB] byte write");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 2'b00, 13'h0031, 32'h0000_005A);
      checkOutput("bw_addr", {19'h0, mem_addr}, 32'h0030);
      checkOutput("bw_wr_en", {30'h0, mem_wr_en}, 32'h1);
      checkOutput("bw_di", {16'h0, mem_di}, 32'h5A5A);
      checkOutput("bw_rd_en", {31'h0, mem_rd_en}, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("bw_valid", {31'h0, d_valid}, 32'h1);
      checkOutput("bw_rdata", d_rdata, 32'h0);
      checkOutput("bw_mem_odd", {24'h0, mem[13'h0031]}, 32'h5A);
      checkOutput("bw_mem_even", {24'h0, mem[13'h0030]}, 32'h77);
      tick();

      $display("[TB] misaligned halfword");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b01, 13'h0041, 32'h0);
      checkOutput("err_gnt", {31'h0, d_gnt}, 32'h1);
      checkOutput("err_mem_en", {31'h0, mem_en}, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("err_valid", {31'h0, d_valid}, 32'h1);
      checkOutput("err_flag", {31'h0, d_err}, 32'h1);
      checkOutput("err_rdata", d_rdata, 32'h0);
      tick();

      $display("[TB] word read with wrap");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b10, 13'h1FFE, 32'h0);
      checkOutput("wrap_addr0", {19'h0, mem_addr}, 32'h1FFE);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("wrap_addr1", {19'h0, mem_addr}, 32'h0000);
      tick();
      checkOutput("wrap_rdata", d_rdata, 32'hDEADBEEF);
      checkOutput("wrap_err", {31'h0, d_err}, 32'h0);
      tick();

      $display("[TB] byte and halfword reads, halfword write");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b00, 13'h0011, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("br_rdata_odd", d_rdata, 32'h000000B2);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b00, 13'h0010, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("br_rdata_even", d_rdata, 32'h000000A1);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b0, 2'b01, 13'h0010, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("hr_rdata", d_rdata, 32'h0000A1B2);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 2'b01, 13'h0050, 32'hABCD1234);
      checkOutput("hw_wr_en", {30'h0, mem_wr_en}, 32'h3);
      checkOutput("hw_di", {16'h0, mem_di}, 32'h1234);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      tick();

      // A lone fetch leaves the last-grant flag at fetch, so data wins first.
      $display("[TB] contention");
      applyStimulus(1'b1, 13'h0010, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      tick();
      applyStimulus(1'b1, 13'h0010, 1'b1, 1'b0, 2'b01, 13'h0010, 32'h0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("cont_d_gnt%0d", k), {31'h0, d_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
         checkOutput($sformatf("cont_if_gnt%0d", k), {31'h0, if_gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
         tick();
         checkOutput($sformatf("cont_resp_gnt%0d", k), {30'h0, d_gnt, if_gnt}, 32'h0);
         checkOutput($sformatf("cont_valid%0d", k), {30'h0, d_valid, if_valid},
                     (k % 2 == 0) ? 32'h2 : 32'h1);
         if (k == 3) applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
         tick();
      end

      $display("[TB] reset during word write");
      applyStimulus(1'b0, 13'h0, 1'b1, 1'b1, 2'b10, 13'h0060, 32'hCAFEF00D);
      checkOutput("rw_di0", {16'h0, mem_di}, 32'hCAFE);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("rw_beat_addr", {19'h0, mem_addr}, 32'h0062);
      checkOutput("rw_beat_di", {16'h0, mem_di}, 32'hF00D);
      rst = 1'b0;
      #1;
      checkOutput("rw_rst_en", {31'h0, mem_en}, 32'h0);
      checkOutput("rw_rst_wr_en", {30'h0, mem_wr_en}, 32'h0);
      checkOutput("rw_rst_addr", {19'h0, mem_addr}, 32'h0);
      checkOutput("rw_rst_di", {16'h0, mem_di}, 32'h0);
      tick();
      checkOutput("rw_rst_valid", {31'h0, d_valid}, 32'h0);
      rst = 1'b1;
      #1;
      checkOutput("rw_rel_valid", {31'h0, d_valid}, 32'h0);
      checkOutput("rw_rel_en", {31'h0, mem_en}, 32'h0);
      tick();
      checkOutput("rw_rel_valid2", {31'h0, d_valid}, 32'h0);
      checkOutput("rw_mem60", {16'h0, mem[13'h0060], mem[13'h0061]}, 32'hCAFE);
      checkOutput("rw_mem62", {16'h0, mem[13'h0062], mem[13'h0063]}, 32'h0000);
      applyStimulus(1'b1, 13'h0020, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("rw_idle_gnt", {31'h0, if_gnt}, 32'h1);
      tick();
      applyStimulus(1'b0, 13'h0, 1'b0, 1'b0, 2'b00, 13'h0, 32'h0);
      checkOutput("rw_idle_data", {16'h0, if_data}, 32'h1122);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, default 2**12, memory size in halfwords; ADDR_WIDTH SHALL be the localparam $clog2(MEM_DEPTH*2), the byte address width.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 i_if_req  input  1  instruction fetch request, held until granted.
REQ-005 i_if_addr  input  ADDR_WIDTH  fetch byte address.
REQ-006 o_if_gnt  output  1  fetch command issued this cycle.
REQ-007 o_if_valid  output  1  fetch data valid, one-cycle pulse.
REQ-008 o_if_data  output  16  fetched halfword.
REQ-009 i_d_req  input  1  data request, held until granted.
REQ-010 i_d_we  input  1  1 = write, 0 = read.
REQ-011 i_d_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-012 i_d_addr  input  ADDR_WIDTH  data byte address.
REQ-013 i_d_wdata  input  32  write data.
REQ-014 o_d_gnt  output  1  data command issued this cycle.
REQ-015 o_d_valid  output  1  data access complete, one-cycle pulse.
REQ-016 o_d_rdata  output  32  read data, zero-extended.
REQ-017 o_d_err  output  1  access rejected, qualified by o_d_valid.
REQ-018 o_mem_addr  output  ADDR_WIDTH  memory byte address, with bit 0 always 0.
REQ-019 o_mem_en, o_mem_rd_en  output  1 each  memory enable and read enable.
REQ-020 o_mem_wr_en  output  [0:1]  per-lane write enables; lane 0 is the even byte.
REQ-021 o_mem_di  output  [0:1][7:0]  write data; lane 0 is the even byte.
REQ-022 i_mem_do  input  [0:1][7:0]  read data, valid on the cycle after a read command.

Function
REQ-023 The FSM SHALL have three states: IDLE, BEAT1 and RESP. Every access SHALL end with exactly one RESP cycle, after which the FSM returns to IDLE.
REQ-024 Commands SHALL be issued only in IDLE and BEAT1. In the grant cycle, the gnt pulse and the first memory command SHALL occur together, combinationally from the request inputs.
REQ-025 Arbitration in IDLE:
- If only one port requests, that port SHALL win.
- If both request, data SHALL win, unless the previous grant went to data, in which case fetch SHALL win.
- The last-grant flag SHALL reset to "fetch".
REQ-026 Fetch: a halfword read at {i_if_addr[ADDR_WIDTH-1:1],0}. In the RESP cycle, o_if_valid SHALL be 1 and o_if_data = {i_mem_do[0], i_mem_do[1]}.
REQ-027 Byte read: the RESP cycle SHALL return o_d_rdata = {24'b0, lane}, where the lane is selected by addr[0].
REQ-028 Halfword read: the RESP cycle SHALL return o_d_rdata = {16'b0, halfword}.
REQ-029 Word read, big-endian:
- Grant cycle: read at addr.
- BEAT1: capture i_mem_do into the high register and issue a read at addr+2. The address SHALL wrap modulo 2**ADDR_WIDTH.
- RESP: o_d_rdata = {high, i_mem_do}.
REQ-030 Byte write: both lanes of o_mem_di SHALL carry wdata[7:0]. o_mem_wr_en SHALL be 2'b10 for an even address and 2'b01 for an odd address. o_mem_rd_en SHALL be 0.
REQ-031 Halfword write: o_mem_di = wdata[15:0] (lane 0 = wdata[15:8]), with o_mem_wr_en = 2'b11.
REQ-032 Word write: wdata[31:16] SHALL be written at addr in the grant cycle, and wdata[15:0] at addr+2 in BEAT1.
REQ-033 Writes SHALL pulse o_d_valid in RESP with o_d_rdata = 0.
REQ-034 Error cases: size 11, or addr[0]=1 with size 01 or 10.
- o_d_gnt SHALL pulse and no memory signal SHALL be asserted.
- RESP SHALL pulse o_d_valid and o_d_err with o_d_rdata = 0.
REQ-035 Idle outputs: when no command is issued, o_mem_en, o_mem_rd_en and o_mem_wr_en SHALL all be 0, and o_mem_addr and o_mem_di SHALL be 0.
REQ-036 The latched request attributes (size, we, addr, wdata, owner) SHALL be held in registers from the grant cycle onward; input changes after the grant SHALL have no effect.
REQ-037 A request asserted during BEAT1 or RESP SHALL wait and be arbitrated in the next IDLE cycle.
REQ-038 Throughput: one halfword or byte access per 2 cycles; one word access per 3 cycles.

Reset
REQ-039 While rst=0:
- State SHALL be IDLE and the last-grant flag SHALL be "fetch".
- All outputs and internal registers SHALL be 0.
- This SHALL take effect immediately, without waiting for a clock edge.
REQ-040 Reset asserted mid-access SHALL discard the access: no valid pulse follows it and no further memory command is issued.

Verification
REQ-041 Fetch read: memory holds 0xA1B2 at byte 0x10; request fetch at 0x10 -> o_if_gnt at T, o_mem_rd_en at T, o_if_valid at T+1 with data 0xA1B2.
REQ-042 Word read: memory holds 0x1122 at 0x20 and 0x3344 at 0x22; request a word read at 0x20 -> addresses 0x20 then 0x22, o_d_valid at T+2 with rdata 0x11223344.
REQ-043 Byte write: write byte 0x5A at 0x31 -> single cycle with o_mem_addr 0x30, o_mem_wr_en 2'b01, both o_mem_di lanes 0x5A; o_d_valid at T+1.
REQ-044 Contention: i_if_req and i_d_req held continuously -> grants alternate data, fetch, data, fetch; neither port waits more than one access.
REQ-045 Error: halfword read at 0x41 -> o_mem_en stays 0, o_d_valid=1 and o_d_err=1 at T+1; word read at 0x1FFE (ADDR_WIDTH=13) -> second beat at 0x0000.
REQ-046 Reset during word write: rst=0 during BEAT1 -> all memory outputs 0 immediately, no o_d_valid, FSM in IDLE after release.
